// File: rtl/ffcp_rx_sack_server_pkg.sv
// ffcp_rx_sack_server_pkg: shared FFCP widths, defaults and packet type codes
package ffcp_rx_sack_server_pkg;
  localparam int FFCP_INDEX_LEN   = 6;
  localparam int FFCP_WINDOW_LEN  = 8;
  localparam int FFCP_SACK_LEN    = FFCP_WINDOW_LEN;
  localparam int FFCP_ACK_HOLDOFF = 16;
  typedef enum logic [1:0] {
    FFCP_TYPE_DATA = 2'd0,
    FFCP_TYPE_SYN  = 2'd1,
    FFCP_TYPE_ACK  = 2'd2,
    FFCP_TYPE_SACK = 2'd3
  } ffcp_type_e;
endpackage

// File: rtl/ffcp_rx_bitmap.sv
// ffcp_rx_bitmap: receive window head, arrival bitmap, window classification and shift-advance
module ffcp_rx_bitmap
  import ffcp_rx_sack_server_pkg::*;
#(
  parameter int INDEX_LEN  = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN = FFCP_WINDOW_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_syn,
  input  logic                  i_inclk,
  input  logic [INDEX_LEN-1:0]  i_in_index,
  output logic [INDEX_LEN-1:0]  o_head,
  output logic [WINDOW_LEN-1:0] o_bitmap,
  output logic                  o_accept,
  output logic                  o_dup,
  output logic                  o_behind,
  output logic                  o_adv
);
  localparam logic [INDEX_LEN-1:0] BEHIND_MIN = INDEX_LEN'((2 ** INDEX_LEN) - WINDOW_LEN);
  logic [INDEX_LEN-1:0]  r_head;
  logic [WINDOW_LEN-1:0] r_bitmap;
  logic [INDEX_LEN-1:0]  w_off;
  logic [WINDOW_LEN-1:0] w_next;
  logic                  w_valid, w_in_win, w_hit;
  // Offset is taken modulo the sequence space so the window survives index wrap
  assign w_off    = i_in_index - r_head;
  assign w_valid  = i_inclk && !i_syn;
  assign w_in_win = w_off < INDEX_LEN'(WINDOW_LEN);
  assign w_hit    = |(r_bitmap & (WINDOW_LEN'(1) << w_off));
  assign o_adv    = r_bitmap[0];
  assign o_accept = w_valid && w_in_win && !w_hit;
  assign o_behind = w_valid && (w_off >= BEHIND_MIN);
  assign o_dup    = o_behind || (w_valid && w_in_win && w_hit);
  assign w_next   = (r_bitmap >> o_adv) | (o_accept ? WINDOW_LEN'(1) << (w_off - INDEX_LEN'(o_adv)) : '0);
  assign o_head   = r_head;
  assign o_bitmap = r_bitmap;
  // Slide the window by at most one slot per cycle while marking the new arrival
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head   <= '0;
      r_bitmap <= '0;
    end else if (i_syn) begin
      r_head   <= INDEX_LEN'(1);
      r_bitmap <= '0;
    end else begin
      r_head   <= r_head + INDEX_LEN'(o_adv);
      r_bitmap <= w_next;
    end
  end
endmodule

// File: rtl/ffcp_rx_sack_server.sv
// ffcp_rx_sack_server: receive window tracker issuing coalesced cumulative acks with SACK bitmap
module ffcp_rx_sack_server
  import ffcp_rx_sack_server_pkg::*;
#(
  parameter int INDEX_LEN   = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN  = FFCP_WINDOW_LEN,
  parameter int ACK_HOLDOFF = FFCP_ACK_HOLDOFF,
  parameter bit SACK_EN     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_syn,
  input  logic                  i_inclk,
  input  logic [INDEX_LEN-1:0]  i_in_index,
  input  logic                  i_downstream_done,
  output logic                  o_accept,
  output logic                  o_dup,
  output logic                  o_outclk,
  output logic [INDEX_LEN-1:0]  o_out_index,
  output logic [WINDOW_LEN-1:0] o_out_sack
);
  localparam int HW = $clog2(ACK_HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ACK_HOLDOFF - 1);
  logic [INDEX_LEN-1:0]  w_head;
  logic [WINDOW_LEN-1:0] w_bitmap;
  logic                  w_behind, w_adv, w_fire;
  logic                  r_ack_pending, r_downstream_rdy;
  logic [HW-1:0]         r_hold_cnt;
  ffcp_rx_bitmap #(
    .INDEX_LEN (INDEX_LEN),
    .WINDOW_LEN(WINDOW_LEN)
  ) u_bitmap (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_syn     (i_syn),
    .i_inclk   (i_inclk),
    .i_in_index(i_in_index),
    .o_head    (w_head),
    .o_bitmap  (w_bitmap),
    .o_accept  (o_accept),
    .o_dup     (o_dup),
    .o_behind  (w_behind),
    .o_adv     (w_adv)
  );
  // A gap in the window acks at once as a retransmit hint; in-order data waits out the holdoff
  assign w_fire = r_ack_pending && !w_bitmap[0] && r_downstream_rdy && !i_inclk &&
                  (r_hold_cnt == HOLD_MAX || |w_bitmap);
  assign o_outclk    = w_fire;
  assign o_out_index = w_head;
  assign o_out_sack  = SACK_EN ? w_bitmap : '0;
  // Ack bookkeeping: pending flag, coalescing timer and downstream handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_pending    <= 1'b0;
      r_hold_cnt       <= '0;
      r_downstream_rdy <= 1'b1;
    end else begin
      r_ack_pending    <= i_syn || w_adv || w_behind || (r_ack_pending && !w_fire);
      r_hold_cnt       <= i_syn ? HOLD_MAX :
                          (!r_ack_pending || w_fire) ? '0 :
                          (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);
      r_downstream_rdy <= w_fire ? 1'b0 : (i_downstream_done || r_downstream_rdy);
    end
  end
endmodule
